pwrite_arbiter: RTL

Shares the single 32-bit host port of the pattern-write controller among NUM_REQ requesters, such as the host bridge, the DMA reader and the test sequencer. Arbitration is round-robin. Requests are issued only while the controller reports ready. A grant stays locked to one requester between the low and high halves of a 64-bit word write, so two requesters' half-words never merge into one word. Read data, which has 1-cycle latency, is steered back to the requester that issued the read.

---
 rtl/pwrite_arbiter_pkg.sv | 12 +
 rtl/pwrite_arbiter_rr_pick.sv | 31 +++
 rtl/pwrite_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pwrite_arbiter_pkg.sv
// rtl/pwrite_arbiter_pkg.sv - shared types and constants for the pattern-write port arbiter
package pwrite_arbiter_pkg;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int MAX_REQ  = 8;
    localparam int WE_BYTES = 4;

endpackage

// File: rtl/pwrite_arbiter_rr_pick.sv
// rtl/pwrite_arbiter_rr_pick.sv - combinational round-robin picker, one-hot grant from pointer
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int   idx;
    logic found;

    // Scan from ptr upward, wrapping once; the first asserted request wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwrite_arbiter.sv
// rtl/pwrite_arbiter.sv - round-robin sharing of the pattern-write host port with 64-bit word locking
module pwrite_arbiter
    import pwrite_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 10,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req_en,
    input  logic [WE_BYTES*NUM_REQ-1:0]    req_we,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]          req_din,
    output logic [NUM_REQ-1:0]             req_gnt,
    output logic [NUM_REQ-1:0]             req_rvalid,
    output logic [31:0]                    req_dout,
    output logic                           lock_timeout_err,
    output logic                           en_out,
    output logic [WE_BYTES-1:0]            we_out,
    output logic [ADDR_WIDTH-1:0]          addr_out,
    output logic [31:0]                    din_out,
    input  logic [31:0]                    dout_in,
    input  logic                           ready_in
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t              state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        rd_owner;
    logic [ADDR_WIDTH-2:0]   lock_word;
    logic [CNT_W-1:0]        lock_cnt;
    logic                    rd_pend;

    logic [NUM_REQ-1:0]      owner_oh;
    logic [NUM_REQ-1:0]      elig;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_any;
    logic [WE_BYTES-1:0]     sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [31:0]             sel_din;
    logic                    is_write;
    logic                    timeout_hit;

    assign owner_oh = NUM_REQ'(1) << owner;

    // Reset and a busy controller both mask every request so the grant path stays quiet.
    always_comb begin
        elig = '0;
        if (resetn && ready_in) begin
            elig = (state == ST_LOCKED) ? (req_en & owner_oh) : req_en;
        end
    end

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (IDX_W)
    ) u_rr_pick (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (req_gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_gnt[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    assign gnt_any  = |req_gnt;
    assign sel_we   = req_we[gnt_idx*WE_BYTES +: WE_BYTES];
    assign sel_addr = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_din  = req_din[gnt_idx*32 +: 32];
    assign is_write = |sel_we;

    assign en_out   = gnt_any;
    assign we_out   = gnt_any ? sel_we   : '0;
    assign addr_out = gnt_any ? sel_addr : '0;
    assign din_out  = gnt_any ? sel_din  : '0;

    assign timeout_hit      = (state == ST_LOCKED) && !gnt_any &&
                              (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1));
    assign lock_timeout_err = timeout_hit;

    assign req_rvalid = rd_pend ? (NUM_REQ'(1) << rd_owner) : '0;
    assign req_dout   = rd_pend ? dout_in : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_OPEN;
            rr_ptr    <= '0;
            owner     <= '0;
            rd_owner  <= '0;
            lock_word <= '0;
            lock_cnt  <= '0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= gnt_any && !is_write;
            if (gnt_any && !is_write) begin
                rd_owner <= gnt_idx;
            end

            case (state)
                ST_OPEN: begin
                    if (gnt_any) begin
                        rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        if (is_write && !sel_addr[0]) begin
                            state     <= ST_LOCKED;
                            owner     <= gnt_idx;
                            lock_word <= sel_addr[ADDR_WIDTH-1:1];
                            lock_cnt  <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!gnt_any) begin
                        if (timeout_hit) begin
                            state    <= ST_OPEN;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end else if (is_write) begin
                        // Any high half closes the lock; a low half to a new word re-arms it there.
                        if (sel_addr[0]) begin
                            state    <= ST_OPEN;
                            lock_cnt <= '0;
                        end else if (sel_addr[ADDR_WIDTH-1:1] != lock_word) begin
                            lock_word <= sel_addr[ADDR_WIDTH-1:1];
                            lock_cnt  <= '0;
                        end
                    end
                end
                default: state <= ST_OPEN;
            endcase
        end
    end

endmodule
